sobel_window_gen: RTL
=====================

// Module: sobel_window_gen
// PURPOSE
//  Streaming 3x3 window generator feeding sobel_core (and other 3x3 kernels).
//  Accepts raster-order pixels over a valid/ready stream and buffers two image lines.
//  Emits one registered 3x3 neighbourhood (px_0..px_8) per interior output pixel.
//  Border pixels produce no window: (IMG_W-2)*(IMG_H-2) windows per frame.
// PARAMETERS
//  DATA_W  15   pixel width; matches sobel_core px_* width
//  IMG_W   640  pixels per line, >= 3
//  IMG_H   480  lines per frame, >= 3
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       in_data/in_sof valid
//  in_ready   out  1       block can accept a pixel this cycle
//  in_data    in   DATA_W  input pixel, raster order
//  in_sof     in   1       qualifies in_data as pixel (0,0) of a new frame
//  out_valid  out  1       px_* hold a valid window
//  out_ready  in   1       downstream accepts window
//  out_eof    out  1       with out_valid: last window of the frame
//  px_0..px_8 out  DATA_W  window: px_0 TL, px_1 T, px_2 TR, px_3 L, px_4 C,
//                          px_5 R, px_6 BL, px_7 B, px_8 BR (px_4 unused by sobel_core)
// BEHAVIOUR
//  Reset (rst_n low, async): col/row counters 0, out_valid 0, out_eof 0, px_* 0,
//   window regs 0; line-buffer RAM not reset (contents don't-care).
//  Handshake: pixel accepted when in_valid && in_ready; window taken when
//   out_valid && out_ready. in_ready = out_ready || !out_valid (combinational).
//   px_*/out_eof stable while out_valid && !out_ready.
//  Accept at position (r,c):
//   - bottom window row shifts left and loads in_data; middle row loads lbuf1[c];
//     top row loads lbuf0[c]; lbuf0[c] <= lbuf1[c]; lbuf1[c] <= in_data (read-before-write).
//   - c wraps IMG_W-1 -> 0 with r+1; at (IMG_H-1, IMG_W-1) both wrap to 0.
//  Window emitted when accepted pixel has r>=2 && c>=2; center is (r-1,c-1).
//   Latency: out_valid high the cycle after that accept; px_8 = that pixel.
//   Accepts with r<2 or c<2 clear out_valid (if not stalled) and emit nothing.
//  out_eof = 1 on the window from pixel (IMG_H-1, IMG_W-1), else 0.
//  in_sof accepted: this pixel taken as (0,0) regardless of counters; prior
//   partial frame discarded; a pending unaccepted window is still delivered first
//   (in_ready low until then). Frame after wrap without in_sof also restarts at (0,0).
//  in_sof on non-accepted cycles ignored. No frame-end input; counters define frame.
//  Throughput: one pixel/cycle when out_ready held high.
//  Counters sized $clog2(IMG_W), $clog2(IMG_H); no arithmetic on pixel data.
// TESTING
//  1 IMG_W=4,IMG_H=4, pixels 1..16, out_ready=1 -> 4 windows; 1st one cycle after
//    pixel 11: px_0..8=1,2,3,5,6,7,9,10,11; last=6,7,8,10,11,12,14,15,16, out_eof=1.
//  2 Same frame, out_ready low 5 cycles on 1st window -> in_ready=0, px_* held,
//    no pixel lost; full 4-window sequence identical to test 1.
//  3 Row wrap: pixels 13,14 (r=3,c=0/1) -> no out_valid; pixel 15 -> window 5..15.
//  4 in_sof after 7 pixels, then full frame 101..116 -> first window 101,102,103,
//    105,106,107,109,110,111; no window contains pixels from aborted frame.
//  5 rst_n low mid-frame (after pixel 12, window pending) -> out_valid/px_* 0
//    immediately; restarted frame 1..16 reproduces test 1.
//  6 Back-to-back frames 1..16 then 17..32, no in_sof -> 8 windows, out_eof on 4th, 8th.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_gen_if : pixel-in / 3x3-window-out stream bundle              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sobel_window_gen_if #(
  parameter int DATA_W = 15
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic              out_eof;
  logic [DATA_W-1:0] px_0, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_eof,
           px_0, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_eof,
           px_0, px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8
  );
endinterface
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_gen : two-line-buffer 3x3 window generator, interior only     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sobel_window_gen #(
  parameter int DATA_W = 15,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          out_valid_q, out_valid_d;
  logic          out_eof_q, out_eof_d;
  logic [8:0][DATA_W-1:0] win_q, win_d;

  logic [DATA_W-1:0] lbuf0 [IMG_W];
  logic [DATA_W-1:0] lbuf1 [IMG_W];
  logic [DATA_W-1:0] rd0, rd1;

  logic in_ready, accept, emit, last;

  always_comb begin
    in_ready = bus.out_ready || !out_valid_q;
    accept   = bus.in_valid && in_ready;
    // An accepted start-of-frame overrides whatever position the counters hold.
    col_eff  = bus.in_sof ? '0 : col_q;
    row_eff  = bus.in_sof ? '0 : row_q;
    rd0      = lbuf0[col_eff];
    rd1      = lbuf1[col_eff];
    emit     = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    last     = (row_eff == c_row_last) && (col_eff == c_col_last);

    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;

    if (accept) begin
      win_d[0]    = win_q[1];
      win_d[1]    = win_q[2];
      win_d[2]    = rd0;
      win_d[3]    = win_q[4];
      win_d[4]    = win_q[5];
      win_d[5]    = rd1;
      win_d[6]    = win_q[7];
      win_d[7]    = win_q[8];
      win_d[8]    = bus.in_data;
      out_valid_d = emit;
      out_eof_d   = emit && last;
      if (col_eff == c_col_last) begin
        col_d = '0;
        row_d = (row_eff == c_row_last) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      win_q       <= win_d;
    end
  end

  // Read-before-write: line 1 ages into line 0 as the new pixel lands in line 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      lbuf0[col_eff] <= rd1;
      lbuf1[col_eff] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.px_0      = win_q[0];
  assign bus.px_1      = win_q[1];
  assign bus.px_2      = win_q[2];
  assign bus.px_3      = win_q[3];
  assign bus.px_4      = win_q[4];
  assign bus.px_5      = win_q[5];
  assign bus.px_6      = win_q[6];
  assign bus.px_7      = win_q[7];
  assign bus.px_8      = win_q[8];

endmodule
`default_nettype wire
